// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity).
package imem_pkg;

   // Widest instruction word the helper functions accept.
   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_LOAD  = 2'd2,
      ST_RUN   = 2'd3
   } state_e;

   // The halt flag is always the most significant instruction bit.
   function automatic int halt_bit(input int iw);
      return iw - 1;
   endfunction

   // NOP encoding: all zeros; callers size-cast to their word width.
   function automatic logic [MAX_W-1:0] nop();
      return '0;
   endfunction

   // Even parity: the returned bit makes the total number of ones even.
   function automatic logic parity(input logic [MAX_W-1:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one registered read
// port, no reset on contents so it maps onto block RAM.
module imem_array #(
   parameter int AW    = 6,
   parameter int DW    = 11,
   parameter int DEPTH = 64
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // Write and registered read; read data holds when re_i is low.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory. After reset the array is cleared
// to NOP, then a program is streamed in over the load port and served over
// a 1-cycle-latency fetch port. Tracks halt bits of fetched words.
// Optional feature macro: IMEM_PARITY_EN (adds load_par_inv / parity_err).
module imem_loadable
   import imem_pkg::*;
#(
   parameter int IW    = 11,
   parameter int AW    = 6,
   parameter int DEPTH = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_start,
   input  logic          load_valid,
   input  logic [IW-1:0] load_data,
   input  logic          load_last,
   output logic          load_ready,
   output logic          load_ovf,
   input  logic [AW-1:0] pc,
   input  logic          fetch_req,
   output logic [IW-1:0] instr,
   output logic          instr_valid,
   output logic          halt_seen,
   output logic          busy
`ifdef IMEM_PARITY_EN
   ,
   input  logic          load_par_inv,
   output logic          parity_err
`endif
);

   localparam int            HALT_BIT  = halt_bit(IW);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
`ifdef IMEM_PARITY_EN
   localparam int            DW        = IW + 1;
`else
   localparam int            DW        = IW;
`endif

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;        // CLEAR sweep / LOAD write pointer
   logic          ovf_q, ovf_d;
   logic          halt_q, halt_d;        // sticky part of halt_seen
   logic          vld_q;
   logic          nop_sel_q;             // last fetch returns NOP (reset or pc out of range)

   logic          accept;
   logic [AW-1:0] eff_addr;
   logic          rd_en;
   logic          pc_oor;
   logic          halt_now;

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   // A load_start accompanying an accepted word restarts the program at 0.
   assign accept   = (state_q == ST_LOAD) && load_valid;
   assign eff_addr = load_start ? '0 : addr_q;
   // Requests arriving with load_start are dropped; the one before completes.
   assign rd_en    = (state_q == ST_RUN) && fetch_req && !load_start;
   assign pc_oor   = ({1'b0, pc} >= (AW+1)'(DEPTH));

   // Write port mux: CLEAR sweeps NOP, LOAD stores accepted words.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = eff_addr;
      mem_wdata = DW'(nop());
      if (state_q == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = addr_q;
      end else if (accept) begin
         mem_we    = 1'b1;
`ifdef IMEM_PARITY_EN
         mem_wdata = {parity(MAX_W'(load_data)) ^ load_par_inv, load_data};
`else
         mem_wdata = load_data;
`endif
      end
   end

   imem_array #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .re_i    (rd_en),
      .raddr_i (pc),
      .rdata_o (mem_rdata)
   );

   assign instr       = nop_sel_q ? '0 : mem_rdata[IW-1:0];
   assign instr_valid = vld_q;
   assign halt_now    = vld_q && instr[HALT_BIT];
   assign halt_seen   = halt_q || halt_now;
   assign load_ovf    = ovf_q;
   assign busy        = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
   assign load_ready  = (state_q == ST_LOAD);

`ifdef IMEM_PARITY_EN
   assign parity_err  = vld_q && !nop_sel_q &&
                        (mem_rdata[IW] != parity(MAX_W'(mem_rdata[IW-1:0])));
`endif

   // Next-state logic for the FSM, write pointer and sticky flags.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ovf_d   = ovf_q;
      halt_d  = halt_q || halt_now;
      case (state_q)
         ST_CLEAR: begin
            if (addr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               addr_d  = '0;
            end else begin
               addr_d  = addr_q + AW'(1);
            end
         end
         ST_IDLE, ST_RUN: begin
            if (load_start) begin
               state_d = ST_LOAD;
               addr_d  = '0;
               ovf_d   = 1'b0;
               halt_d  = 1'b0;
            end
         end
         ST_LOAD: begin
            if (load_start) begin
               addr_d = '0;
               ovf_d  = 1'b0;
               halt_d = 1'b0;
            end
            if (accept) begin
               if (load_last) begin
                  state_d = ST_RUN;
               end else if (eff_addr == LAST_ADDR) begin
                  state_d = ST_RUN;
                  ovf_d   = 1'b1;
               end else begin
                  addr_d  = eff_addr + AW'(1);
               end
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // State and flag registers; reset restarts the CLEAR sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         addr_q    <= '0;
         ovf_q     <= 1'b0;
         halt_q    <= 1'b0;
         vld_q     <= 1'b0;
         nop_sel_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         ovf_q     <= ovf_d;
         halt_q    <= halt_d;
         vld_q     <= rd_en;
         if (rd_en) begin
            nop_sel_q <= pc_oor;
         end
      end
   end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed testbench for imem_loadable. Build with +define+IMEM_PARITY_EN
// to exercise the parity test hook as well.
module tb_imem_loadable;

   localparam int IW    = 11;
   localparam int AW    = 6;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_start;
   logic          load_valid;
   logic [IW-1:0] load_data;
   logic          load_last;
   logic          load_ready;
   logic          load_ovf;
   logic [AW-1:0] pc;
   logic          fetch_req;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic          halt_seen;
   logic          busy;
`ifdef IMEM_PARITY_EN
   logic          load_par_inv;
   logic          parity_err;
`endif

   int            n_checks = 0;
   int            n_fail   = 0;
   int            par_inv_idx = -1;
   int            acc;
   logic [IW-1:0] prog [0:79];
   logic [IW-1:0] old1, old2;

   always #5 clk = ~clk;

   imem_loadable #(
      .IW    (IW),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_start   (load_start),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_last    (load_last),
      .load_ready   (load_ready),
      .load_ovf     (load_ovf),
      .pc           (pc),
      .fetch_req    (fetch_req),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .halt_seen    (halt_seen),
      .busy         (busy)
`ifdef IMEM_PARITY_EN
      ,
      .load_par_inv (load_par_inv),
      .parity_err   (parity_err)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after rst_n rises: busy must stay high for DEPTH cycles.
   task automatic wait_clear(input string tag);
      int hi;
      hi = 0;
      check_eq({tag, "_busy0"}, busy, 1);
      check_eq({tag, "_ready"}, load_ready, 0);
      for (int i = 0; i < DEPTH - 1; i++) begin
         tick();
         if (busy === 1'b1) hi++;
      end
      check_eq({tag, "_busy_len"}, hi, DEPTH - 1);
      tick();
      check_eq({tag, "_busy_end"}, busy, 0);
   endtask

   // Stream prog[0..n-1]; optional idle gap before each word.
   task automatic load_seq(input int n, input bit mark_last, input bit gap,
                           input bit do_start, output int n_acc);
      n_acc = 0;
      if (do_start) begin
         load_start = 1'b1;
         tick();
         load_start = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         if (gap) begin
            load_valid = 1'b0;
            check_eq("ready_in_gap", load_ready, 1);
            tick();
         end
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = mark_last && (i == n - 1);
`ifdef IMEM_PARITY_EN
         load_par_inv = (i == par_inv_idx);
`endif
         if (load_ready === 1'b1) n_acc++;
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
`ifdef IMEM_PARITY_EN
      load_par_inv = 1'b0;
`endif
   endtask

   task automatic fetch1(input int a, input logic [IW-1:0] exp, input string tag);
      pc        = AW'(a);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      check_eq({tag, "_valid"}, instr_valid, 1);
      check_eq(tag, instr, exp);
   endtask

   initial begin
      rst_n      = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      pc         = '0;
      fetch_req  = 1'b0;
`ifdef IMEM_PARITY_EN
      load_par_inv = 1'b0;
`endif
      repeat (3) tick();

      // Reset values
      check_eq("rst_busy", busy, 1);
      check_eq("rst_ready", load_ready, 0);
      check_eq("rst_ovf", load_ovf, 0);
      check_eq("rst_valid", instr_valid, 0);
      check_eq("rst_instr", instr, 0);
      check_eq("rst_halt", halt_seen, 0);

      rst_n = 1'b1;
      wait_clear("clear1");

      // IDLE ignores fetches
      pc = AW'(5); fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      check_eq("idle_fetch_valid", instr_valid, 0);

      // Empty program, then fetch an untouched cleared location
      prog[0] = '0;
      load_seq(1, 1'b1, 1'b0, 1'b1, acc);
      check_eq("empty_acc", acc, 1);
      check_eq("empty_run_busy", busy, 0);
      check_eq("empty_ovf", load_ovf, 0);
      fetch1(5, 11'h000, "empty_pc5");
      tick();
      check_eq("noreq_valid", instr_valid, 0);

      // Three-word program, back-to-back fetches
      prog[0] = 11'h201; prog[1] = 11'h2A5; prog[2] = 11'h40E;
      load_seq(3, 1'b1, 1'b0, 1'b1, acc);
      check_eq("p3_acc", acc, 3);
      check_eq("p3_halt_pre", halt_seen, 0);
      pc = AW'(0); fetch_req = 1'b1;
      tick();
      check_eq("b2b0_valid", instr_valid, 1);
      check_eq("b2b0_instr", instr, 11'h201);
      check_eq("b2b0_halt", halt_seen, 0);
      pc = AW'(1);
      tick();
      check_eq("b2b1_valid", instr_valid, 1);
      check_eq("b2b1_instr", instr, 11'h2A5);
      check_eq("b2b1_halt", halt_seen, 0);
      pc = AW'(2);
      tick();
      fetch_req = 1'b0;
      check_eq("b2b2_valid", instr_valid, 1);
      check_eq("b2b2_instr", instr, 11'h40E);
      check_eq("b2b2_halt", halt_seen, 1);
      tick();
      check_eq("hold_valid", instr_valid, 0);
      check_eq("hold_instr", instr, 11'h40E);
      check_eq("hold_halt", halt_seen, 1);

      // Gapped load: no holes, no duplicates
      prog[0] = 11'h011; prog[1] = 11'h022; prog[2] = 11'h033; prog[3] = 11'h044;
      load_seq(4, 1'b1, 1'b1, 1'b1, acc);
      check_eq("gap_acc", acc, 4);
      check_eq("gap_halt_cleared", halt_seen, 0);
      fetch1(0, 11'h011, "gap_pc0");
      fetch1(1, 11'h022, "gap_pc1");
      fetch1(2, 11'h033, "gap_pc2");
      fetch1(3, 11'h044, "gap_pc3");
      fetch1(4, 11'h000, "gap_pc4");

      // Overflow: 65 words offered, 64 taken
      for (int i = 0; i < 65; i++) prog[i] = IW'((i * 7 + 3) & 'h3FF);
      prog[63] = prog[63] | 11'h400;
      old1 = prog[1];
      old2 = prog[2];
      load_seq(65, 1'b0, 1'b0, 1'b1, acc);
      check_eq("ovf_acc", acc, 64);
      check_eq("ovf_flag", load_ovf, 1);
      check_eq("ovf_run_busy", busy, 0);
      fetch1(63, prog[63], "ovf_pc63");
      fetch1(1, old1, "ovf_pc1");
      check_eq("ovf_halt", halt_seen, 1);

      // Reload from RUN with a fetch in flight
      pc = AW'(2); fetch_req = 1'b1;
      tick();
      load_start = 1'b1;
      pc = AW'(3);
      check_eq("inflight_valid", instr_valid, 1);
      check_eq("inflight_instr", instr, old2);
      tick();
      load_start = 1'b0;
      fetch_req  = 1'b0;
      check_eq("restart_req_ignored", instr_valid, 0);
      check_eq("restart_halt", halt_seen, 0);
      check_eq("restart_ovf", load_ovf, 0);
      check_eq("restart_busy", busy, 1);
      check_eq("restart_ready", load_ready, 1);
      prog[0] = 11'h123;
      load_seq(1, 1'b1, 1'b0, 1'b0, acc);
      check_eq("restart_acc", acc, 1);
      fetch1(0, 11'h123, "reload_pc0");
      fetch1(1, old1, "reload_pc1_old");

      // Asynchronous reset in the middle of a load
      prog[0] = 11'h055; prog[1] = 11'h066;
      load_seq(2, 1'b0, 1'b0, 1'b1, acc);
      check_eq("midload_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_busy", busy, 1);
      check_eq("arst_ready", load_ready, 0);
      check_eq("arst_valid", instr_valid, 0);
      check_eq("arst_instr", instr, 0);
      check_eq("arst_halt", halt_seen, 0);
      check_eq("arst_ovf", load_ovf, 0);
      tick();
      rst_n = 1'b1;
      wait_clear("clear2");
      prog[0] = '0;
      load_seq(1, 1'b1, 1'b0, 1'b1, acc);
      fetch1(1, 11'h000, "recleared_pc1");

`ifdef IMEM_PARITY_EN
      // Parity test hook: corrupt the stored parity of word 2 only
      prog[0] = 11'h003; prog[1] = 11'h005; prog[2] = 11'h007;
      par_inv_idx = 2;
      load_seq(3, 1'b1, 1'b0, 1'b1, acc);
      par_inv_idx = -1;
      fetch1(2, 11'h007, "par_pc2");
      check_eq("par_err_pc2", parity_err, 1);
      fetch1(1, 11'h005, "par_pc1");
      check_eq("par_err_pc1", parity_err, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, run-time loadable instruction memory for the small register-machine core. It replaces the fixed combinational program ROM.
- The program is streamed in over a valid/ready load port after reset. Instructions are then served to the core over a registered fetch port with 1-cycle latency.
- Tracks the halt bit of fetched instructions so the core and test bench can see end-of-program.

Parameters:
- IW, 11, instruction width in bits; bit IW-1 is the halt bit.
- AW, 6, pc and address width.
- DEPTH, 64, number of stored words; must satisfy 2 <= DEPTH <= 2**AW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  1-cycle pulse: begin (re)programming at address 0.
- load_valid  in  1  load word present.
- load_data  in  IW  instruction word to store.
- load_last  in  1  qualifies load_data as the final word.
- load_ready  out  1  load word accepted when load_valid && load_ready.
- load_ovf  out  1  sticky: program longer than DEPTH.
- pc  in  AW  fetch address.
- fetch_req  in  1  fetch request.
- instr  out  IW  fetched instruction.
- instr_valid  out  1  instr is valid this cycle.
- halt_seen  out  1  sticky: a fetched instr had bit IW-1 set.
- busy  out  1  high in CLEAR and LOAD.

Behaviour:
- Reset values: all outputs are 0, except busy = 1. The FSM enters CLEAR. Memory contents are not reset directly.
- FSM states: CLEAR, IDLE, LOAD, RUN.
- CLEAR:
  - Writes NOP (all zeros) to address 0..DEPTH-1, one address per cycle.
  - After writing DEPTH-1, moves to IDLE. CLEAR lasts exactly DEPTH cycles.
  - load_start during CLEAR is ignored. load_ready = 0.
- IDLE:
  - load_start -> LOAD; write address wr_addr = 0; clears load_ovf and halt_seen.
  - fetch_req is ignored; instr_valid stays 0.
- LOAD:
  - load_ready = 1.
  - On each accept, mem[wr_addr] <= load_data and wr_addr increments.
  - Accept with load_last = 1 -> RUN on the next cycle.
  - Accept at wr_addr = DEPTH-1 without load_last -> RUN, and load_ovf <= 1.
  - load_start in LOAD restarts at wr_addr = 0. Words already written stay in memory.
  - Locations not written keep NOP from CLEAR or their previous program.
- RUN:
  - fetch_req at cycle t -> instr = mem[pc] and instr_valid = 1 at t+1.
  - No fetch_req -> instr_valid = 0 and instr holds its value.
  - pc >= DEPTH returns NOP with instr_valid = 1.
  - Back-to-back requests give one result per cycle.
  - A valid instr with bit IW-1 set sets halt_seen on that same cycle edge. halt_seen holds until load_start or reset.
  - load_start in RUN -> LOAD. A fetch outstanding from the previous cycle still completes. Requests from then on are ignored.
- busy = 1 exactly in CLEAR and LOAD.
- load_ready is a registered function of state only; it never depends on load_valid.
- Reset assertion at any time, including mid-CLEAR or mid-LOAD, restarts CLEAR.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed at write. CLEAR writes parity 0.
  - Adds input load_par_inv (1), which inverts the stored parity of the accepted word; this is a test hook.
  - Adds output parity_err (1), registered alongside instr_valid. It is high when a fetched word's parity mismatches; NOP for pc >= DEPTH never flags. Reset value is 0.
- Undefined: no extra ports, no parity storage, behaviour exactly as above.

Decomposition:
- Package imem_pkg holds:
  - state enum (CLEAR, IDLE, LOAD, RUN);
  - function nop(IW) returning all zeros;
  - localparam HALT_BIT = IW-1 convention;
  - parity function.
- One sub-module, imem_array: DEPTH x (IW[+1]) storage, one synchronous write port, one synchronous read port, no reset on contents.
- The FSM, counters and flags live in imem_loadable.

Test Plan:
- Reset, then wait: busy = 1 for 64 cycles after rst_n rises; next cycle busy = 0. Fetch in RUN after an empty load (first word 0 with load_last) at pc = 5 -> instr = 0.
- Load 3 words 0x201, 0x2A5, 0x40E (last); fetch pc = 0, 1, 2 back-to-back -> instr 0x201, 0x2A5, 0x40E on consecutive cycles, instr_valid = 1; halt_seen = 1 on the third result.
- Load with load_valid toggled every other cycle and load_ready checked -> words land at consecutive addresses with no gaps or duplicates.
- Stream 65 words, none marked last -> 64 accepted, load_ovf = 1, RUN entered; fetch pc = 63 returns word 63.
- In RUN with halt_seen = 1, pulse load_start, then load 0x123 (last) -> halt_seen = 0 and load_ovf = 0; pc = 0 returns 0x123, pc = 1 returns the old program's word 1.
- Assert rst_n = 0 mid-LOAD -> all outputs reset immediately, busy = 1, CLEAR reruns. With IMEM_PARITY_EN: load with load_par_inv on word 2 -> fetch pc = 2 gives parity_err = 1; pc = 1 gives parity_err = 0.
